// File: rtl/sequence_detector_param.sv
// rtl/sequence_detector_param.sv - runtime-programmable digit-sequence detector with overlap control
module sequence_detector_param #(
    parameter int                               DIGIT_W     = 4,
    parameter int                               SEQ_LEN     = 4,
    parameter logic [SEQ_LEN*DIGIT_W-1:0]       DEFAULT_SEQ = 16'h1094,
    parameter int                               CNT_W       = 8,
    localparam int                              PROG_W      = $clog2(SEQ_LEN+1),
    localparam int                              SEQ_W       = SEQ_LEN*DIGIT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] number,
    input  logic               number_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [SEQ_W-1:0]   cfg_seq,
    output logic               pattern,
    output logic [PROG_W-1:0]  progress,
    output logic [CNT_W-1:0]   match_count
);

    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [DIGIT_W-1:0] hist_q [SEQ_LEN-1];
    logic [DIGIT_W-1:0] hist_d [SEQ_LEN-1];
    logic [PROG_W-1:0]  hist_cnt_q, hist_cnt_d;
    logic [PROG_W-1:0]  progress_q, progress_d;
    logic               pattern_q, pattern_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;

    logic [DIGIT_W-1:0] cand [SEQ_LEN];
    logic [PROG_W-1:0]  l_new;
    logic [PROG_W-1:0]  border_len;
    logic               full_match;

    function automatic logic [DIGIT_W-1:0] seq_digit(input logic [SEQ_W-1:0] s, input int j);
        return s[(SEQ_LEN-1-j)*DIGIT_W +: DIGIT_W];
    endfunction

    // Candidate string: history (oldest first) followed by the incoming digit.
    always_comb begin
        for (int k = 0; k < SEQ_LEN-1; k++) begin
            cand[k] = hist_q[k];
        end
        cand[SEQ_LEN-1] = number;
    end

    // Longest sequence prefix ending at the incoming digit; only digits since the last barrier count.
    always_comb begin
        logic ok;
        ok    = 1'b0;
        l_new = '0;
        for (int l = 1; l <= SEQ_LEN; l++) begin
            ok = ((l - 1) <= int'(hist_cnt_q));
            for (int j = 0; j < l; j++) begin
                if (cand[SEQ_LEN-l+j] != seq_digit(seq_q, j)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                l_new = PROG_W'(l);
            end
        end
    end

    assign full_match = (l_new == PROG_W'(SEQ_LEN));

    // Longest proper prefix that is also a suffix: where progress resumes after an overlapping match.
    always_comb begin
        logic ok;
        ok         = 1'b0;
        border_len = '0;
        for (int b = 1; b < SEQ_LEN; b++) begin
            ok = 1'b1;
            for (int j = 0; j < b; j++) begin
                if (seq_digit(seq_q, j) != seq_digit(seq_q, SEQ_LEN-b+j)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                border_len = PROG_W'(b);
            end
        end
    end

    always_comb begin
        seq_d         = seq_q;
        hist_d        = hist_q;
        hist_cnt_d    = hist_cnt_q;
        progress_d    = progress_q;
        pattern_d     = 1'b0;
        match_count_d = match_count_q;

        if (cfg_load) begin
            seq_d         = cfg_seq;
            hist_cnt_d    = '0;
            progress_d    = '0;
            match_count_d = '0;
        end else if (number_valid) begin
            for (int k = 0; k < SEQ_LEN-2; k++) begin
                hist_d[k] = hist_q[k+1];
            end
            hist_d[SEQ_LEN-2] = number;
            if (hist_cnt_q != PROG_W'(SEQ_LEN-1)) begin
                hist_cnt_d = hist_cnt_q + PROG_W'(1);
            end

            if (full_match) begin
                pattern_d = 1'b1;
                if (match_count_q != {CNT_W{1'b1}}) begin
                    match_count_d = match_count_q + CNT_W'(1);
                end
                if (overlap) begin
                    progress_d = border_len;
                end else begin
                    progress_d = '0;
                    hist_cnt_d = '0;
                end
            end else begin
                progress_d = l_new;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_q         <= DEFAULT_SEQ;
            for (int k = 0; k < SEQ_LEN-1; k++) begin
                hist_q[k] <= '0;
            end
            hist_cnt_q    <= '0;
            progress_q    <= '0;
            pattern_q     <= 1'b0;
            match_count_q <= '0;
        end else begin
            seq_q         <= seq_d;
            hist_q        <= hist_d;
            hist_cnt_q    <= hist_cnt_d;
            progress_q    <= progress_d;
            pattern_q     <= pattern_d;
            match_count_q <= match_count_d;
        end
    end

    assign pattern     = pattern_q;
    assign progress    = progress_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_sequence_detector_param.sv
// tb/tb_sequence_detector_param.sv - scoreboard bench for sequence_detector_param
module tb_sequence_detector_param;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  number = '0;
    logic        number_valid = 1'b0;
    logic        overlap = 1'b1;
    logic        cfg_load = 1'b0;
    logic [15:0] cfg_seq = '0;
    logic        pattern, pattern_s;
    logic [2:0]  progress, progress_s;
    logic [7:0]  match_count;
    logic [1:0]  count_s;

    int checks = 0;
    int errors = 0;

    sequence_detector_param dut (
        .clock(clock), .reset(reset), .number(number), .number_valid(number_valid),
        .overlap(overlap), .cfg_load(cfg_load), .cfg_seq(cfg_seq),
        .pattern(pattern), .progress(progress), .match_count(match_count)
    );

    sequence_detector_param #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .number(number), .number_valid(number_valid),
        .overlap(overlap), .cfg_load(cfg_load), .cfg_seq(cfg_seq),
        .pattern(pattern_s), .progress(progress_s), .match_count(count_s)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit pat;
        int prog;
        int cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model: eligible digits since the last barrier, kept as a plain list.
    int m_seq[4];
    int m_hist[$];
    int m_prog;
    int m_cnt;
    bit m_pat;
    bit cur_ovl = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int border();
        int best = 0;
        bit ok;
        for (int b = 1; b < 4; b++) begin
            ok = 1'b1;
            for (int j = 0; j < b; j++)
                if (m_seq[j] != m_seq[4-b+j]) ok = 1'b0;
            if (ok) best = b;
        end
        return best;
    endfunction

    task automatic model_reset();
        m_seq = '{1, 0, 9, 4};
        m_hist.delete();
        m_prog = 0;
        m_cnt  = 0;
        m_pat  = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit ovl, input bit ld, input logic [15:0] cs);
        int cand[$];
        int lnew;
        bit ok;
        lnew = 0;
        if (ld) begin
            for (int j = 0; j < 4; j++) m_seq[j] = int'(cs[15-4*j -: 4]);
            m_hist.delete();
            m_prog = 0;
            m_cnt  = 0;
            m_pat  = 1'b0;
        end else if (v) begin
            cand = m_hist;
            cand.push_back(d);
            for (int l = 1; l <= 4; l++) begin
                ok = (l <= cand.size());
                if (ok)
                    for (int j = 0; j < l; j++)
                        if (cand[cand.size()-l+j] != m_seq[j]) ok = 1'b0;
                if (ok) lnew = l;
            end
            while (cand.size() > 4) void'(cand.pop_front());
            if (lnew == 4) begin
                m_pat = 1'b1;
                m_cnt++;
                if (ovl) begin
                    m_prog = border();
                    m_hist = cand;
                end else begin
                    m_prog = 0;
                    m_hist.delete();
                end
            end else begin
                m_pat  = 1'b0;
                m_prog = lnew;
                m_hist = cand;
            end
        end else begin
            m_pat = 1'b0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.pat  = m_pat;
        e.prog = m_prog;
        e.cnt  = m_cnt;
        sb.push_back(e);
    endtask

    task automatic step(input bit v, input int d, input bit ld, input logic [15:0] cs);
        @(negedge clock);
        number_valid = v;
        number       = 4'(d);
        cfg_load     = ld;
        cfg_seq      = cs;
        overlap      = cur_ovl;
        model_edge(v, d, cur_ovl, ld, cs);
        push_exp();
    endtask

    task automatic send(input int d);
        step(1'b1, d, 1'b0, 16'h0);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 16'h0);
    endtask

    task automatic load(input logic [15:0] cs);
        step(1'b0, 0, 1'b1, cs);
    endtask

    task automatic send_1094();
        send(1); send(0); send(9); send(4);
    endtask

    task automatic send_1212x3();
        send(1); send(2); send(1); send(2); send(1); send(2);
    endtask

    // Monitor: every cycle after the edge, pop the prediction made for that edge.
    exp_t mon_e;
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("pattern", int'(pattern), int'(mon_e.pat));
            chk("progress", int'(progress), mon_e.prog);
            chk("match_count", int'(match_count), (mon_e.cnt > 255) ? 255 : mon_e.cnt);
            chk("match_count_sat", int'(count_s), (mon_e.cnt > 3) ? 3 : mon_e.cnt);
            chk("pattern_sat", int'(pattern_s), int'(mon_e.pat));
        end
    end

    initial begin
        logic [15:0] rs;
        int d;
        int w;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_pattern", int'(pattern), 0);
        chk("reset_progress", int'(progress), 0);
        chk("reset_count", int'(match_count), 0);
        @(negedge clock);
        reset = 1'b0;

        send_1094(); idle();
        send(1); idle(); idle(); idle(); send(0); send(9); send(4);
        send(1); send(0); send(1); send(0); send(9); send(4); idle();

        load(16'h1212);
        cur_ovl = 1'b1; send_1212x3();
        load(16'h1212);
        cur_ovl = 1'b0; send_1212x3();
        cur_ovl = 1'b1;

        load(16'h1094);
        send(1); send(0); send(9);
        step(1'b1, 4, 1'b1, 16'h1094);
        idle();

        send(1); send(0); send(9);
        @(negedge clock);
        number_valid = 1'b0;
        cfg_load     = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("async_progress", int'(progress), 0);
        chk("async_pattern", int'(pattern), 0);
        #1 reset = 1'b0;
        model_edge(1'b0, 0, cur_ovl, 1'b0, 16'h0);
        push_exp();
        send(4); idle();

        repeat (5) send_1094();
        idle();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) cur_ovl = ~cur_ovl;
            if ($urandom_range(0, 99) < 2) begin
                for (int j = 0; j < 4; j++)
                    rs[15-4*j -: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
                step(1'b1, $urandom_range(0, 15), 1'b1, rs);
            end else begin
                d = ($urandom_range(0, 9) < 7) ? m_seq[$urandom_range(0, 3)] : $urandom_range(0, 15);
                step($urandom_range(0, 9) < 8, d, 1'b0, 16'h0);
            end
        end

        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(posedge clock);
            w++;
        end
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
